// File: rtl/mram_access_arbiter.sv
// mram_access_arbiter
//   Shares one parallel MRAM port between two requesters. Round-robin
//   arbitration latches the winning command, then the FSM walks the active-low
//   strobes through SETUP, ACCESS and RECOVER phases. It returns read data and
//   a one-cycle completion pulse to the granted port.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-low reset
//   req/we/addr/wdata 0 : port 0 command (req held until ack0)
//   req/we/addr/wdata 1 : port 1 command (req held until ack1)
//   ack0, ack1          : one-cycle completion pulse per port
//   rdata               : read data, valid in the ack cycle, held afterwards
//   busy                : high whenever the FSM is not idle
//   mram_addr           : MRAM address bus
//   mram_dq_out/_oe     : write data and its bus-drive enable
//   mram_dq_in          : data returned from the MRAM
//   chip_en, write_en, out_en, lower_byte_en, upper_byte_en : MRAM strobes, active-low
module mram_access_arbiter #(
  parameter int SETUP_CYC   = 2,
  parameter int ACCESS_CYC  = 3,
  parameter int RECOVER_CYC = 1,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mram_addr,
  output logic [DATA_W-1:0] mram_dq_out,
  output logic              mram_dq_oe,
  input  logic [DATA_W-1:0] mram_dq_in,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  // Phase counter counts down to zero; the load value is length-1.
  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] ACCESS_LD  = 8'(ACCESS_CYC - 1);
  localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);

  state_t            state, state_d;
  logic [7:0]        cnt, cnt_d;
  logic              rr_ptr, rr_ptr_d;
  logic              cmd_we, cmd_we_d;
  logic              cmd_port, cmd_port_d;
  logic              win;

  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dq_out_d, rdata_d;
  logic              active, first_rec;
  logic              dq_oe_d, ack0_d, ack1_d, busy_d;
  logic              chip_en_d, write_en_d, out_en_d;

  // Next-state logic, including arbitration and command latching.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rr_ptr_d   = rr_ptr;
    cmd_we_d   = cmd_we;
    cmd_port_d = cmd_port;
    win        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) begin
            win      = rr_ptr;
            rr_ptr_d = ~rr_ptr;
          end else begin
            win = req1;
          end
          cmd_port_d = win;
          cmd_we_d   = win ? we1 : we0;
          state_d    = SETUP;
          cnt_d      = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_d = ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      ACCESS: begin
        if (cnt == 8'd0) begin
          state_d = RECOVER;
          cnt_d   = RECOVER_LD;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output logic: every output is computed from the next state so that the
  // registered pins line up with the state they describe.
  always_comb begin
    addr_d   = mram_addr;
    dq_out_d = mram_dq_out;
    rdata_d  = rdata;
    // mram_addr / mram_dq_out double as the latched command address and data.
    if (state == IDLE && state_d == SETUP) begin
      addr_d = win ? addr1 : addr0;
      if (cmd_we_d) dq_out_d = win ? wdata1 : wdata0;
    end
    // Read data is sampled at the edge that closes the last ACCESS cycle.
    if (state == ACCESS && cnt == 8'd0 && !cmd_we) rdata_d = mram_dq_in;

    active     = (state_d == SETUP) || (state_d == ACCESS);
    first_rec  = (state == ACCESS) && (state_d == RECOVER);
    chip_en_d  = ~active;
    write_en_d = ~((state_d == ACCESS) && cmd_we_d);
    out_en_d   = ~((state_d == ACCESS) && !cmd_we_d);
    // Write data stays driven through the first RECOVER cycle for hold time.
    dq_oe_d    = cmd_we_d && (active || first_rec);
    ack0_d     = first_rec && !cmd_port;
    ack1_d     = first_rec && cmd_port;
    busy_d     = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      rr_ptr        <= 1'b0;
      cmd_we        <= 1'b0;
      cmd_port      <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      busy          <= 1'b0;
      rdata         <= '0;
      mram_addr     <= '0;
      mram_dq_out   <= '0;
      mram_dq_oe    <= 1'b0;
      chip_en       <= 1'b1;
      write_en      <= 1'b1;
      out_en        <= 1'b1;
      lower_byte_en <= 1'b1;
      upper_byte_en <= 1'b1;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      rr_ptr        <= rr_ptr_d;
      cmd_we        <= cmd_we_d;
      cmd_port      <= cmd_port_d;
      ack0          <= ack0_d;
      ack1          <= ack1_d;
      busy          <= busy_d;
      rdata         <= rdata_d;
      mram_addr     <= addr_d;
      mram_dq_out   <= dq_out_d;
      mram_dq_oe    <= dq_oe_d;
      chip_en       <= chip_en_d;
      write_en      <= write_en_d;
      out_en        <= out_en_d;
      lower_byte_en <= chip_en_d;
      upper_byte_en <= chip_en_d;
    end
  end

endmodule

// File: tb/tb_mram_access_arbiter.sv
// Directed bench for mram_access_arbiter: a default-parameter instance and a
// SETUP/ACCESS/RECOVER = 1/1/1 instance sharing clock and reset.
module tb_mram_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Default instance
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [19:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0, mram_dq_in = '0;
  logic        ack0, ack1, busy, mram_dq_oe;
  logic        chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
  logic [15:0] rdata, mram_dq_out;
  logic [19:0] mram_addr;
  logic [4:0]  strb;
  assign strb = {chip_en, write_en, out_en, lower_byte_en, upper_byte_en};

  // Minimum-timing instance
  logic        req0_b = 0, we0_b = 0, req1_b = 0, we1_b = 0;
  logic [19:0] addr0_b = '0, addr1_b = '0;
  logic [15:0] wdata0_b = '0, wdata1_b = '0, mram_dq_in_b = '0;
  logic        ack0_b, ack1_b, busy_b, mram_dq_oe_b;
  logic        chip_en_b, write_en_b, out_en_b, lower_byte_en_b, upper_byte_en_b;
  logic [15:0] rdata_b, mram_dq_out_b;
  logic [19:0] mram_addr_b;
  logic [4:0]  strb_b;
  assign strb_b = {chip_en_b, write_en_b, out_en_b, lower_byte_en_b, upper_byte_en_b};

  // Strobe patterns {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}
  localparam logic [4:0] S_OFF   = 5'b11111;
  localparam logic [4:0] S_SETUP = 5'b01100;
  localparam logic [4:0] S_WR    = 5'b00100;
  localparam logic [4:0] S_RD    = 5'b01000;

  mram_access_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mram_addr(mram_addr),
    .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe), .mram_dq_in(mram_dq_in),
    .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
    .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en)
  );

  mram_access_arbiter #(.SETUP_CYC(1), .ACCESS_CYC(1), .RECOVER_CYC(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b),
    .rdata(rdata_b), .busy(busy_b), .mram_addr(mram_addr_b),
    .mram_dq_out(mram_dq_out_b), .mram_dq_oe(mram_dq_oe_b), .mram_dq_in(mram_dq_in_b),
    .chip_en(chip_en_b), .write_en(write_en_b), .out_en(out_en_b),
    .lower_byte_en(lower_byte_en_b), .upper_byte_en(upper_byte_en_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Strobe sanity on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("excl_we_oe", {31'd0, (write_en === 1'b0 && out_en === 1'b0)}, 32'd0);
      chk("excl_we_oe_b", {31'd0, (write_en_b === 1'b0 && out_en_b === 1'b0)}, 32'd0);
      if (!busy_b || ack0_b || ack1_b) chk("ce_idle_rec_b", {31'd0, chip_en_b}, 32'd1);
      if (!busy || ack0 || ack1) chk("ce_idle_rec", {31'd0, chip_en}, 32'd1);
    end
  end

  initial begin
    // Reset state
    tick_n(3);
    chk("rst_strb", strb, S_OFF);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", mram_addr, 0);
    chk("rst_dq_out", mram_dq_out, 0);
    chk("rst_dq_oe", mram_dq_oe, 0);
    chk("rst_strb_b", strb_b, S_OFF);
    rst = 1'b1;
    tick();

    // Port 0 single write (cycle t)
    req0 = 1; we0 = 1; addr0 = 20'h0_1234; wdata0 = 16'hA5A5;
    tick(); // t+1
    chk("w_addr", mram_addr, 20'h01234);
    chk("w_setup_strb", strb, S_SETUP);
    chk("w_setup_oe", mram_dq_oe, 1);
    chk("w_busy", busy, 1);
    tick_n(2); // t+3
    chk("w_acc_strb_3", strb, S_WR);
    chk("w_dq_out", mram_dq_out, 16'hA5A5);
    chk("w_acc_oe", mram_dq_oe, 1);
    tick_n(2); // t+5
    chk("w_acc_strb_5", strb, S_WR);
    chk("w_ack0_early", ack0, 0);
    tick(); // t+6
    chk("w_ack0", ack0, 1);
    chk("w_ack1", ack1, 0);
    chk("w_rec_strb", strb, S_OFF);
    chk("w_rec_oe", mram_dq_oe, 1);
    chk("w_rec_addr", mram_addr, 20'h01234);
    req0 = 0;
    tick(); // t+7
    chk("w_busy_end", busy, 0);
    chk("w_ack0_end", ack0, 0);
    chk("w_oe_end", mram_dq_oe, 0);

    // Port 1 read; data only becomes valid late in ACCESS
    req1 = 1; we1 = 0; addr1 = 20'hF_FFFF; mram_dq_in = 16'h1111;
    tick(); // t+1
    chk("r_addr", mram_addr, 20'hFFFFF);
    chk("r_setup_strb", strb, S_SETUP);
    chk("r_setup_oe", mram_dq_oe, 0);
    tick_n(2); // t+3
    chk("r_acc_strb_3", strb, S_RD);
    chk("r_acc_oe", mram_dq_oe, 0);
    tick_n(2); // t+5
    chk("r_acc_strb_5", strb, S_RD);
    mram_dq_in = 16'h5A3C;
    tick(); // t+6
    chk("r_rdata", rdata, 16'h5A3C);
    chk("r_ack1", ack1, 1);
    chk("r_ack0", ack0, 0);
    req1 = 0;
    mram_dq_in = 16'hFFFF;
    tick(); // t+7
    chk("r_busy_end", busy, 0);
    chk("r_rdata_hold", rdata, 16'h5A3C);

    // Simultaneous requests after reset: acks alternate 0,1,0,1
    rst = 0; tick(); rst = 1; tick();
    req0 = 1; we0 = 1; addr0 = 20'h00AAA; wdata0 = 16'h1234;
    req1 = 1; we1 = 0; addr1 = 20'h00BBB; mram_dq_in = 16'hBEEF;
    for (int i = 1; i <= 27; i++) begin
      tick();
      chk("sim_ack0", ack0, (i == 6 || i == 20) ? 1 : 0);
      chk("sim_ack1", ack1, (i == 13 || i == 27) ? 1 : 0);
      if (i == 1) chk("sim_addr_p0", mram_addr, 20'h00AAA);
      if (i == 8) chk("sim_addr_p1", mram_addr, 20'h00BBB);
      if (i == 13) chk("sim_rdata", rdata, 16'hBEEF);
    end
    req0 = 0; req1 = 0;
    tick();

    // Mid-transaction reset: rr_ptr moves to port 1, then reset returns it to 0
    req0 = 1; we0 = 1; addr0 = 20'h00C0C; wdata0 = 16'h0F0F;
    req1 = 1; we1 = 0; addr1 = 20'h00D0D;
    tick_n(4); // t+4, inside ACCESS
    chk("mr_acc_strb", strb, S_WR);
    rst = 0; req0 = 0; req1 = 0;
    tick(); // t+5
    chk("mr_strb", strb, S_OFF);
    chk("mr_busy", busy, 0);
    chk("mr_oe", mram_dq_oe, 0);
    chk("mr_ack0", ack0, 0);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_ack0", ack0, 0);
      chk("mr_no_ack1", ack1, 0);
      chk("mr_idle", busy, 0);
    end
    req0 = 1; req1 = 1;
    tick(); // port 0 must win again
    chk("mr_rr_reset", mram_addr, 20'h00C0C);
    tick_n(5);
    chk("mr_ack0_after", ack0, 1);
    req0 = 0; req1 = 0;
    tick();
    chk("mr_busy_end", busy, 0);

    // Request withdrawn after latch
    req0 = 1; we0 = 0; addr0 = 20'h00055; mram_dq_in = 16'hCAFE;
    tick(); // t+1
    req0 = 0;
    chk("wd_busy", busy, 1);
    tick_n(5); // t+6
    chk("wd_ack0", ack0, 1);
    chk("wd_rdata", rdata, 16'hCAFE);
    tick(); // t+7
    chk("wd_idle7", busy, 0);
    tick(); // t+8
    chk("wd_idle8", busy, 0);
    chk("wd_strb8", strb, S_OFF);

    // Minimum-timing instance: read, then a write granted one IDLE cycle later
    req1_b = 1; we1_b = 0; addr1_b = 20'h00321; mram_dq_in_b = 16'h1357;
    tick(); // t+1
    chk("b_setup_strb", strb_b, S_SETUP);
    chk("b_busy", busy_b, 1);
    tick(); // t+2
    chk("b_acc_strb", strb_b, S_RD);
    chk("b_ack1_early", ack1_b, 0);
    tick(); // t+3
    chk("b_ack1", ack1_b, 1);
    chk("b_rdata", rdata_b, 16'h1357);
    chk("b_rec_strb", strb_b, S_OFF);
    req1_b = 0;
    req0_b = 1; we0_b = 1; addr0_b = 20'h00777; wdata0_b = 16'h7777;
    tick(); // t+4
    chk("b_idle_busy", busy_b, 0);
    chk("b_ack1_end", ack1_b, 0);
    tick(); // t+5
    chk("b_w_setup", strb_b, S_SETUP);
    chk("b_w_addr", mram_addr_b, 20'h00777);
    chk("b_w_dq", mram_dq_out_b, 16'h7777);
    chk("b_w_oe", mram_dq_oe_b, 1);
    tick(); // t+6
    chk("b_w_acc", strb_b, S_WR);
    tick(); // t+7
    chk("b_w_ack0", ack0_b, 1);
    chk("b_w_rec_oe", mram_dq_oe_b, 1);
    req0_b = 0;
    tick(); // t+8
    chk("b_w_oe_end", mram_dq_oe_b, 0);
    chk("b_w_busy_end", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
